// File: rtl/layer_out_reader_if.sv
// Result stream from layer_out_reader to the downstream consumer:
// buffered node words under a valid/ready handshake, plus the argmax class.
interface layer_out_reader_if #(
    parameter int IDX_W = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             class_valid;
    logic [IDX_W-1:0] class_id;

    modport master (
        output out_valid, out_data, out_index, out_last, class_valid, class_id,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last, class_valid, class_id,
        output out_ready
    );
endinterface

// File: rtl/layer_out_reader.sv
// Snapshots the last layer's node outputs after the pipeline latency, streams
// them out one word per handshake and reports the argmax node index.
module layer_out_reader #(
    parameter int NUM_NODES = 4,
    parameter int LATENCY   = 3,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [16*NUM_NODES-1:0] n_bus,
    output logic                   busy,
    layer_out_reader_if.master     res
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      node_buf [NUM_NODES];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [15:0]      best_val;
    logic [IDX_W-1:0] best_idx;
    logic             xfer;
    logic             better;

    // out_data always mirrors node_buf[idx] in SEND, so compare against it.
    always_comb begin
        xfer     = res.out_valid && res.out_ready;
        idx_next = idx + IDX_W'(1);
        better   = res.out_data > best_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            idx             <= '0;
            best_val        <= '0;
            best_idx        <= '0;
            busy            <= 1'b0;
            res.out_valid   <= 1'b0;
            res.out_data    <= '0;
            res.out_index   <= '0;
            res.out_last    <= 1'b0;
            res.class_valid <= 1'b0;
            res.class_id    <= '0;
            // NOTE: the snapshot buffer is cleared explicitly so a frame aborted by
            // reset never leaves stale node values behind.
            for (int i = 0; i < NUM_NODES; i++) node_buf[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge values of idx, best_val and the outputs.
            res.class_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        busy  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        for (int i = 0; i < NUM_NODES; i++) node_buf[i] <= n_bus[16*i +: 16];
                        idx           <= '0;
                        best_val      <= '0;
                        best_idx      <= '0;
                        res.out_valid <= 1'b1;
                        res.out_data  <= n_bus[15:0];
                        res.out_index <= '0;
                        res.out_last  <= 1'b0;
                        state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        if (better) begin
                            best_val <= res.out_data;
                            best_idx <= idx;
                        end
                        if (res.out_last) begin
                            // Final argmax must include the word transferring right now.
                            res.out_valid   <= 1'b0;
                            res.out_last    <= 1'b0;
                            res.class_valid <= 1'b1;
                            res.class_id    <= better ? idx : best_idx;
                            state           <= S_DONE;
                        end else begin
                            idx           <= idx_next;
                            res.out_data  <= node_buf[idx_next];
                            res.out_index <= idx_next;
                            res.out_last  <= (idx_next == LAST_IDX);
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_out_reader.sv
// Randomised scoreboard bench for layer_out_reader: stimulus pushes expected
// words/classes from a plain argmax model, a negedge monitor pops and compares.
module tb_layer_out_reader;
    localparam int NUM_NODES = 4;
    localparam int LATENCY   = 3;
    localparam int IDX_W     = 4;

    typedef logic [15:0] vec_t [NUM_NODES];
    typedef struct {
        logic [15:0]      data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } word_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [16*NUM_NODES-1:0] n_bus;
    logic                    busy;

    layer_out_reader_if #(.IDX_W(IDX_W)) dut_if ();

    layer_out_reader #(
        .NUM_NODES(NUM_NODES),
        .LATENCY  (LATENCY),
        .IDX_W    (IDX_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .n_bus(n_bus),
        .busy (busy),
        .res  (dut_if)
    );

    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    int    xfers       = 0;
    int    prev_cls    = 0;
    word_t exp_words[$];
    int    exp_cls[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the maximum value (ties keep lower index).
    function automatic int argmax(input vec_t v);
        int b = 0;
        for (int i = 1; i < NUM_NODES; i++) if (v[i] > v[b]) b = i;
        return b;
    endfunction

    // Monitor: transfers complete at the next rising edge, inputs only change at posedge+1.
    logic             hold_pending = 1'b0;
    logic [15:0]      hold_data;
    logic [IDX_W-1:0] hold_index;
    logic             hold_last;

    always @(negedge clk) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("stall_valid", 32'(dut_if.out_valid), 32'd1);
                check("stall_data", 32'(dut_if.out_data), 32'(hold_data));
                check("stall_index", 32'(dut_if.out_index), 32'(hold_index));
                check("stall_last", 32'(dut_if.out_last), 32'(hold_last));
            end
            hold_pending = dut_if.out_valid && !dut_if.out_ready;
            hold_data    = dut_if.out_data;
            hold_index   = dut_if.out_index;
            hold_last    = dut_if.out_last;
            if (dut_if.out_valid && dut_if.out_ready) begin
                if (exp_words.size() == 0) begin
                    check("unexpected_word", 32'(dut_if.out_index), 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_words.pop_front();
                    check("word_data", 32'(dut_if.out_data), 32'(w.data));
                    check("word_index", 32'(dut_if.out_index), 32'(w.idx));
                    check("word_last", 32'(dut_if.out_last), 32'(w.last));
                end
                xfers++;
            end
            if (dut_if.class_valid) begin
                if (exp_cls.size() == 0) check("unexpected_class", 32'(dut_if.class_id), 32'hFFFF_FFFF);
                else check("class_id", 32'(dut_if.class_id), 32'(exp_cls.pop_front()));
            end
        end
    end

    // mode: 0 ready held high with exact timing, 1 random ready, 2 stall on index 2,
    // 3 start pulses while busy, 4 reset after the second transfer
    task automatic frame(input vec_t vals, input int mode);
        int k;
        int x0;
        int stall;
        for (int i = 0; i < NUM_NODES; i++) begin
            word_t w;
            w.data = vals[i];
            w.idx  = IDX_W'(i);
            w.last = (i == NUM_NODES - 1);
            exp_words.push_back(w);
        end
        if (mode != 4) exp_cls.push_back(argmax(vals));
        x0    = xfers;
        stall = 0;
        n_bus = {$urandom(), $urandom()};
        dut_if.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_in_wait", 32'(dut_if.out_valid), 32'd0);
        k = 0;
        while (busy && k < 200) begin
            start = (mode == 3) && (k == 1 || k == LATENCY + 1);
            if (k == LATENCY - 1)
                for (int i = 0; i < NUM_NODES; i++) n_bus[16*i +: 16] = vals[i];
            if (k == LATENCY) n_bus = {NUM_NODES{16'h7FFF}};
            case (mode)
                1: dut_if.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (dut_if.out_valid && dut_if.out_index == 2 && stall < 3) begin
                        dut_if.out_ready = 1'b0;
                        stall++;
                    end else begin
                        dut_if.out_ready = 1'b1;
                    end
                end
                4: begin
                    if (xfers - x0 >= 2) begin
                        reset = 1'b1;
                        dut_if.out_ready = 1'b0;
                        tick();
                        reset = 1'b0;
                        check("rst_out_valid", 32'(dut_if.out_valid), 32'd0);
                        check("rst_busy", 32'(busy), 32'd0);
                        check("rst_class_id", 32'(dut_if.class_id), 32'd0);
                        check("rst_class_valid", 32'(dut_if.class_valid), 32'd0);
                        check("rst_xfers", 32'(xfers - x0), 32'd2);
                        exp_words.delete();
                        prev_cls = 0;
                        dut_if.out_ready = 1'b1;
                        return;
                    end
                end
                default: dut_if.out_ready = 1'b1;
            endcase
            tick();
            k++;
            if (k == LATENCY) begin
                check("capture_valid", 32'(dut_if.out_valid), 32'd1);
                check("capture_data", 32'(dut_if.out_data), 32'(vals[0]));
                check("capture_index", 32'(dut_if.out_index), 32'd0);
                check("class_held", 32'(dut_if.class_id), 32'(prev_cls));
            end
            if (mode == 0 && k == LATENCY + NUM_NODES) begin
                check("done_class_valid", 32'(dut_if.class_valid), 32'd1);
                check("done_out_valid", 32'(dut_if.out_valid), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
            end
            if (mode == 0 && k == LATENCY + NUM_NODES + 1) begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_class_valid", 32'(dut_if.class_valid), 32'd0);
            end
        end
        start = 1'b0;
        check("frame_timeout", 32'(busy), 32'd0);
        if (mode == 3) check("one_frame_words", 32'(xfers - x0), 32'(NUM_NODES));
        prev_cls = argmax(vals);
    endtask

    initial begin
        vec_t vals;
        reset = 1'b1;
        start = 1'b1;
        n_bus = '1;
        dut_if.out_ready = 1'b1;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(dut_if.out_valid), 32'd0);
        check("reset_out_data", 32'(dut_if.out_data), 32'd0);
        check("reset_out_index", 32'(dut_if.out_index), 32'd0);
        check("reset_out_last", 32'(dut_if.out_last), 32'd0);
        check("reset_class_valid", 32'(dut_if.class_valid), 32'd0);
        check("reset_class_id", 32'(dut_if.class_id), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();

        vals = '{16'h0010, 16'h0200, 16'h0050, 16'h0000};
        frame(vals, 0);
        vals = '{16'h0100, 16'h0300, 16'h0300, 16'h0000};
        frame(vals, 0);
        vals = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        frame(vals, 0);
        vals = '{16'h0010, 16'h0200, 16'h0050, 16'h0000};
        frame(vals, 2);
        vals = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000};
        frame(vals, 3);
        vals = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
        frame(vals, 4);
        vals = '{16'h0010, 16'h0200, 16'h0050, 16'h0000};
        frame(vals, 0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NUM_NODES; i++)
                vals[i] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom());
            frame(vals, (r % 6 == 5) ? 2 : 1);
        end

        repeat (4) tick();
        check("words_drained", 32'(exp_words.size()), 32'd0);
        check("classes_drained", 32'(exp_cls.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
